// File: rtl/sync_width_conv_fifo.sv
// -----------------------------------------------------------------------------
// sync_width_conv_fifo
//
// Single-clock FIFO that converts between write and read word widths of any
// integer ratio, in either direction. Data is stored as narrow granules
// (N = min(WR_DATA_WIDTH, RD_DATA_WIDTH) bits). The store is split into
// G = max(WR_G, RD_G) banks so the wide side touches one address in every bank
// per access and the narrow side touches one address in one bank.
//
// Ports:
//   clk            clock for all logic
//   rst            asynchronous active-high reset, clears all state
//   clr            synchronous flush, discards contents (rd_data holds)
//   wr_en          write request, accepted when wr_full is low
//   wr_data        write word
//   wr_full        fewer free granules than one write word needs
//   almost_full    wr_water_level >= ALMOST_FULL_NUM
//   wr_water_level stored data in write words (rounded down)
//   rd_en          read request, accepted when rd_empty is low
//   rd_data        read word, updated on the edge that accepts the read
//   rd_empty       fewer stored granules than one read word needs
//   almost_empty   rd_water_level <= ALMOST_EMPTY_NUM
//   rd_water_level stored data in read words (rounded down)
// -----------------------------------------------------------------------------
module sync_width_conv_fifo #(
    parameter int WR_DATA_WIDTH    = 16,
    parameter int RD_DATA_WIDTH    = 128,
    parameter int DEPTH_WIDTH      = 11,
    parameter int LSB_FIRST        = 1,
    parameter int ALMOST_FULL_NUM  = 2040,
    parameter int ALMOST_EMPTY_NUM = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     wr_en,
    input  logic [WR_DATA_WIDTH-1:0] wr_data,
    output logic                     wr_full,
    output logic                     almost_full,
    output logic [DEPTH_WIDTH:0]     wr_water_level,
    input  logic                     rd_en,
    output logic [RD_DATA_WIDTH-1:0] rd_data,
    output logic                     rd_empty,
    output logic                     almost_empty,
    output logic [DEPTH_WIDTH:0]     rd_water_level
);

    localparam int N          = (WR_DATA_WIDTH < RD_DATA_WIDTH) ? WR_DATA_WIDTH : RD_DATA_WIDTH;
    localparam int WR_G       = WR_DATA_WIDTH / N;
    localparam int RD_G       = RD_DATA_WIDTH / N;
    localparam int G          = (WR_G > RD_G) ? WR_G : RD_G;
    localparam int DEPTH      = 1 << DEPTH_WIDTH;
    localparam int GW         = $clog2(G);
    localparam int BW         = (GW > 0) ? GW : 1;
    localparam int AW         = DEPTH_WIDTH - GW;
    localparam int BANK_DEPTH = 1 << AW;

    typedef logic [DEPTH_WIDTH:0]   lvl_t;
    typedef logic [DEPTH_WIDTH-1:0] ptr_t;

    localparam lvl_t WR_G_C   = lvl_t'(WR_G);
    localparam lvl_t RD_G_C   = lvl_t'(RD_G);
    localparam lvl_t FULL_LIM = lvl_t'(DEPTH - WR_G);
    localparam lvl_t AF_C     = lvl_t'(ALMOST_FULL_NUM);
    localparam lvl_t AE_C     = lvl_t'(ALMOST_EMPTY_NUM);

    generate
        if ((WR_DATA_WIDTH % RD_DATA_WIDTH != 0) && (RD_DATA_WIDTH % WR_DATA_WIDTH != 0)) begin : g_bad_ratio
            $error("sync_width_conv_fifo: wider port must be an integer multiple of the narrower one");
        end
        if (DEPTH % G != 0) begin : g_bad_depth
            $error("sync_width_conv_fifo: capacity must be a multiple of the wide word size");
        end
    endgenerate

    // ---------------------------------------------------------------------
    // Pointer / count state
    // ---------------------------------------------------------------------
    ptr_t wr_ptr_q, rd_ptr_q;
    lvl_t cnt_q, cnt_d;
    logic wr_full_q, almost_full_q, rd_empty_q, almost_empty_q;
    lvl_t wr_level_q, rd_level_q;
    lvl_t wr_level_d, rd_level_d;

    // clr wins over both ports: a concurrent write is dropped and a
    // concurrent read is not performed so rd_data keeps its value.
    logic wr_accept, rd_accept;
    assign wr_accept = wr_en & ~wr_full_q & ~clr;
    assign rd_accept = rd_en & ~rd_empty_q & ~clr;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + (wr_accept ? WR_G_C : lvl_t'(0)) - (rd_accept ? RD_G_C : lvl_t'(0));
        end
    end

    assign wr_level_d = cnt_d / WR_G_C;
    assign rd_level_d = cnt_d / RD_G_C;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            cnt_q          <= '0;
            wr_full_q      <= 1'b0;
            almost_full_q  <= 1'b0;
            rd_empty_q     <= 1'b1;
            almost_empty_q <= 1'b1;
            wr_level_q     <= '0;
            rd_level_q     <= '0;
        end else begin
            if (clr) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (wr_accept) wr_ptr_q <= wr_ptr_q + ptr_t'(WR_G);
                if (rd_accept) rd_ptr_q <= rd_ptr_q + ptr_t'(RD_G);
            end
            cnt_q          <= cnt_d;
            wr_full_q      <= (cnt_d > FULL_LIM);
            rd_empty_q     <= (cnt_d < RD_G_C);
            wr_level_q     <= wr_level_d;
            rd_level_q     <= rd_level_d;
            almost_full_q  <= (wr_level_d >= AF_C);
            almost_empty_q <= (rd_level_d <= AE_C);
        end
    end

    assign wr_full        = wr_full_q;
    assign almost_full    = almost_full_q;
    assign wr_water_level = wr_level_q;
    assign rd_empty       = rd_empty_q;
    assign almost_empty   = almost_empty_q;
    assign rd_water_level = rd_level_q;

    // ---------------------------------------------------------------------
    // Bank addressing: low pointer bits pick the bank, high bits the row.
    // The wide-side pointer is always bank-aligned.
    // ---------------------------------------------------------------------
    logic [BW-1:0] wr_bank, rd_bank;
    logic [AW-1:0] wr_addr, rd_addr;

    generate
        if (GW > 0) begin : g_split_ptr
            assign wr_bank = wr_ptr_q[BW-1:0];
            assign rd_bank = rd_ptr_q[BW-1:0];
            assign wr_addr = wr_ptr_q[DEPTH_WIDTH-1:GW];
            assign rd_addr = rd_ptr_q[DEPTH_WIDTH-1:GW];
        end else begin : g_flat_ptr
            assign wr_bank = '0;
            assign rd_bank = '0;
            assign wr_addr = wr_ptr_q;
            assign rd_addr = rd_ptr_q;
        end
    endgenerate

    // Granule read registers laid out in wide-word bit order.
    logic [G*N-1:0] gran_flat;

    genvar gi;
    generate
        for (gi = 0; gi < G; gi++) begin : g_bank
            // Bit slot of this bank inside a wide word; bank 0 holds the
            // first granule in stream order.
            localparam int POS = (LSB_FIRST != 0) ? gi : (G - 1 - gi);

            logic [N-1:0] mem [BANK_DEPTH];
            logic [N-1:0] wr_gran;
            logic [N-1:0] gran_q;
            logic         we, re;

            if (WR_G == G) begin : g_wide_wr
                assign wr_gran = wr_data[POS*N +: N];
            end else begin : g_narrow_wr
                assign wr_gran = wr_data;
            end

            assign we = wr_accept && ((WR_G == G) || (wr_bank == BW'(gi)));
            assign re = rd_accept && ((RD_G == G) || (rd_bank == BW'(gi)));

            always_ff @(posedge clk) begin
                if (we) mem[wr_addr] <= wr_gran;
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    gran_q <= '0;
                end else if (re) begin
                    gran_q <= mem[rd_addr];
                end
            end

            assign gran_flat[POS*N +: N] = gran_q;
        end

        if (RD_G == G) begin : g_wide_rd
            assign rd_data = gran_flat;
        end else begin : g_narrow_rd
            // Remember which bit slot the last accepted read landed in.
            logic [BW-1:0] rd_pos_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rd_pos_q <= '0;
                end else if (rd_accept) begin
                    rd_pos_q <= (LSB_FIRST != 0) ? rd_bank : (BW'(G - 1) - rd_bank);
                end
            end

            assign rd_data = gran_flat[rd_pos_q*N +: N];
        end
    endgenerate

endmodule

// File: tb/tb_sync_width_conv_fifo.sv
module tb_sync_width_conv_fifo;

    logic clk;
    logic rst;

    // Up-converting instance (defaults: 16 -> 128, LSB first)
    logic         up_clr, up_wr_en, up_rd_en;
    logic [15:0]  up_wr_data;
    logic [127:0] up_rd_data;
    logic         up_wr_full, up_almost_full, up_rd_empty, up_almost_empty;
    logic [11:0]  up_wr_level, up_rd_level;

    // Down-converting instance (128 -> 16, MSB first, 64 granules)
    logic         dn_clr, dn_wr_en, dn_rd_en;
    logic [127:0] dn_wr_data;
    logic [15:0]  dn_rd_data;
    logic         dn_wr_full, dn_almost_full, dn_rd_empty, dn_almost_empty;
    logic [6:0]   dn_wr_level, dn_rd_level;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [127:0] EXP_PACK = 128'h0008_0007_0006_0005_0004_0003_0002_0001;

    sync_width_conv_fifo u_up (
        .clk(clk), .rst(rst), .clr(up_clr),
        .wr_en(up_wr_en), .wr_data(up_wr_data),
        .wr_full(up_wr_full), .almost_full(up_almost_full), .wr_water_level(up_wr_level),
        .rd_en(up_rd_en), .rd_data(up_rd_data),
        .rd_empty(up_rd_empty), .almost_empty(up_almost_empty), .rd_water_level(up_rd_level)
    );

    sync_width_conv_fifo #(
        .WR_DATA_WIDTH(128), .RD_DATA_WIDTH(16), .DEPTH_WIDTH(6),
        .LSB_FIRST(0), .ALMOST_FULL_NUM(7), .ALMOST_EMPTY_NUM(2)
    ) u_dn (
        .clk(clk), .rst(rst), .clr(dn_clr),
        .wr_en(dn_wr_en), .wr_data(dn_wr_data),
        .wr_full(dn_wr_full), .almost_full(dn_almost_full), .wr_water_level(dn_wr_level),
        .rd_en(dn_rd_en), .rd_data(dn_rd_data),
        .rd_empty(dn_rd_empty), .almost_empty(dn_almost_empty), .rd_water_level(dn_rd_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        n_checks++; if (up_rd_empty !== 1'b1)     begin n_fail++; $display("FAIL reset_rd_empty got %b exp 1", up_rd_empty); end
        n_checks++; if (up_almost_empty !== 1'b1) begin n_fail++; $display("FAIL reset_almost_empty got %b exp 1", up_almost_empty); end
        n_checks++; if (up_wr_full !== 1'b0)      begin n_fail++; $display("FAIL reset_wr_full got %b exp 0", up_wr_full); end
        n_checks++; if (up_almost_full !== 1'b0)  begin n_fail++; $display("FAIL reset_almost_full got %b exp 0", up_almost_full); end
        n_checks++; if (up_wr_level !== 12'd0)    begin n_fail++; $display("FAIL reset_wr_level got %0d exp 0", up_wr_level); end
        n_checks++; if (up_rd_level !== 12'd0)    begin n_fail++; $display("FAIL reset_rd_level got %0d exp 0", up_rd_level); end
        n_checks++; if (up_rd_data !== 128'd0)    begin n_fail++; $display("FAIL reset_rd_data got %h exp 0", up_rd_data); end
        n_checks++; if (dn_rd_data !== 16'd0)     begin n_fail++; $display("FAIL reset_dn_rd_data got %h exp 0", dn_rd_data); end
        rst = 1'b0;
        tick();
        n_checks++; if (up_rd_empty !== 1'b1 || up_wr_level !== 12'd0 || up_rd_data !== 128'd0)
            begin n_fail++; $display("FAIL reset_hold got empty=%b lvl=%0d data=%h exp 1/0/0", up_rd_empty, up_wr_level, up_rd_data); end
        n_checks++; if (dn_rd_empty !== 1'b1 || dn_wr_full !== 1'b0)
            begin n_fail++; $display("FAIL reset_dn_flags got empty=%b full=%b exp 1/0", dn_rd_empty, dn_wr_full); end
        $display("test_reset done");
    endtask

    task automatic test_pack();
        for (int i = 1; i <= 8; i++) begin
            up_wr_en = 1'b1; up_wr_data = 16'(i);
            tick();
            $display("up write %0d data %h", i, 16'(i));
            n_checks++; if (up_rd_empty !== (i < 8))
                begin n_fail++; $display("FAIL pack_rd_empty_w%0d got %b exp %b", i, up_rd_empty, (i < 8)); end
        end
        up_wr_en = 1'b0;
        n_checks++; if (up_rd_level !== 12'd1) begin n_fail++; $display("FAIL pack_rd_level got %0d exp 1", up_rd_level); end
        n_checks++; if (up_wr_level !== 12'd8) begin n_fail++; $display("FAIL pack_wr_level got %0d exp 8", up_wr_level); end
        up_rd_en = 1'b1;
        tick();
        up_rd_en = 1'b0;
        $display("up read data %h", up_rd_data);
        n_checks++; if (up_rd_data !== EXP_PACK) begin n_fail++; $display("FAIL pack_rd_data got %h exp %h", up_rd_data, EXP_PACK); end
        n_checks++; if (up_rd_empty !== 1'b1)    begin n_fail++; $display("FAIL pack_rd_empty_after got %b exp 1", up_rd_empty); end
        n_checks++; if (up_wr_level !== 12'd0)   begin n_fail++; $display("FAIL pack_wr_level_after got %0d exp 0", up_wr_level); end
    endtask

    task automatic test_partial();
        for (int i = 0; i < 7; i++) begin
            up_wr_en = 1'b1; up_wr_data = 16'h0011 + 16'(i);
            tick();
        end
        up_wr_en = 1'b0;
        n_checks++; if (up_wr_level !== 12'd7) begin n_fail++; $display("FAIL partial_wr_level got %0d exp 7", up_wr_level); end
        n_checks++; if (up_rd_level !== 12'd0) begin n_fail++; $display("FAIL partial_rd_level got %0d exp 0", up_rd_level); end
        n_checks++; if (up_rd_empty !== 1'b1)  begin n_fail++; $display("FAIL partial_rd_empty got %b exp 1", up_rd_empty); end
        up_rd_en = 1'b1;
        tick();
        up_rd_en = 1'b0;
        $display("up read on empty, data %h", up_rd_data);
        n_checks++; if (up_rd_data !== EXP_PACK) begin n_fail++; $display("FAIL partial_rd_hold got %h exp %h", up_rd_data, EXP_PACK); end
        n_checks++; if (up_wr_level !== 12'd7)   begin n_fail++; $display("FAIL partial_level_kept got %0d exp 7", up_wr_level); end
    endtask

    task automatic test_clear();
        for (int i = 0; i < 93; i++) begin
            up_wr_en = 1'b1; up_wr_data = 16'h0100 + 16'(i);
            tick();
        end
        n_checks++; if (up_wr_level !== 12'd100) begin n_fail++; $display("FAIL clr_pre_level got %0d exp 100", up_wr_level); end
        up_clr = 1'b1; up_wr_en = 1'b1; up_wr_data = 16'hDEAD;
        tick();
        up_clr = 1'b0; up_wr_en = 1'b0;
        $display("up clr with concurrent write");
        n_checks++; if (up_wr_level !== 12'd0)     begin n_fail++; $display("FAIL clr_wr_level got %0d exp 0", up_wr_level); end
        n_checks++; if (up_rd_empty !== 1'b1)      begin n_fail++; $display("FAIL clr_rd_empty got %b exp 1", up_rd_empty); end
        n_checks++; if (up_almost_empty !== 1'b1)  begin n_fail++; $display("FAIL clr_almost_empty got %b exp 1", up_almost_empty); end
        n_checks++; if (up_rd_data !== EXP_PACK)   begin n_fail++; $display("FAIL clr_rd_data got %h exp %h", up_rd_data, EXP_PACK); end
        tick();
        n_checks++; if (up_wr_level !== 12'd0)     begin n_fail++; $display("FAIL clr_write_discarded got %0d exp 0", up_wr_level); end
    endtask

    task automatic test_fill_and_wrap();
        logic [127:0] exp_word;
        for (int i = 0; i < 2048; i++) begin
            up_wr_en = 1'b1; up_wr_data = 16'(i);
            tick();
            if (i == 2038) begin n_checks++; if (up_almost_full !== 1'b0) begin n_fail++; $display("FAIL fill_af_2039 got %b exp 0", up_almost_full); end end
            if (i == 2039) begin n_checks++; if (up_almost_full !== 1'b1) begin n_fail++; $display("FAIL fill_af_2040 got %b exp 1", up_almost_full); end end
            if (i == 2046) begin n_checks++; if (up_wr_full !== 1'b0)     begin n_fail++; $display("FAIL fill_full_2047 got %b exp 0", up_wr_full); end end
            if (i == 2047) begin n_checks++; if (up_wr_full !== 1'b1)     begin n_fail++; $display("FAIL fill_full_2048 got %b exp 1", up_wr_full); end end
        end
        $display("up filled 2048 words");
        n_checks++; if (up_wr_level !== 12'd2048) begin n_fail++; $display("FAIL fill_wr_level got %0d exp 2048", up_wr_level); end
        n_checks++; if (up_rd_level !== 12'd256)  begin n_fail++; $display("FAIL fill_rd_level got %0d exp 256", up_rd_level); end
        up_wr_data = 16'hBEEF;
        tick();
        n_checks++; if (up_wr_level !== 12'd2048) begin n_fail++; $display("FAIL full_write_ignored got %0d exp 2048", up_wr_level); end
        up_rd_en = 1'b1; up_wr_data = 16'hCAFE;
        tick();
        up_wr_en = 1'b0;
        exp_word = 128'h0007_0006_0005_0004_0003_0002_0001_0000;
        $display("up simultaneous wr/rd while full, data %h", up_rd_data);
        n_checks++; if (up_rd_data !== exp_word)  begin n_fail++; $display("FAIL full_rw_data got %h exp %h", up_rd_data, exp_word); end
        n_checks++; if (up_wr_level !== 12'd2040) begin n_fail++; $display("FAIL full_rw_level got %0d exp 2040", up_wr_level); end
        n_checks++; if (up_wr_full !== 1'b0)      begin n_fail++; $display("FAIL full_rw_wr_full got %b exp 0", up_wr_full); end
        n_checks++; if (up_almost_full !== 1'b1)  begin n_fail++; $display("FAIL full_rw_af got %b exp 1", up_almost_full); end
        // Drain the remaining 255 words; this crosses the read pointer wrap.
        for (int k = 1; k < 256; k++) begin
            tick();
            for (int j = 0; j < 8; j++) exp_word[j*16 +: 16] = 16'(8*k + j);
            n_checks++; if (up_rd_data !== exp_word)
                begin n_fail++; $display("FAIL drain_data_%0d got %h exp %h", k, up_rd_data, exp_word); end
            n_checks++; if (up_almost_empty !== ((255 - k) <= 4))
                begin n_fail++; $display("FAIL drain_ae_%0d got %b exp %b", k, up_almost_empty, ((255 - k) <= 4)); end
        end
        up_rd_en = 1'b0;
        $display("up drained, last data %h", up_rd_data);
        n_checks++; if (up_rd_empty !== 1'b1) begin n_fail++; $display("FAIL drain_empty got %b exp 1", up_rd_empty); end
        // Pointers have wrapped back to zero; run one more word through.
        for (int j = 0; j < 8; j++) begin
            up_wr_en = 1'b1; up_wr_data = 16'hA000 + 16'(j);
            tick();
        end
        up_wr_en = 1'b0; up_rd_en = 1'b1;
        tick();
        up_rd_en = 1'b0;
        exp_word = 128'hA007_A006_A005_A004_A003_A002_A001_A000;
        $display("up post-wrap read data %h", up_rd_data);
        n_checks++; if (up_rd_data !== exp_word) begin n_fail++; $display("FAIL wrap_data got %h exp %h", up_rd_data, exp_word); end
    endtask

    task automatic test_down();
        logic [127:0] w;
        logic [15:0]  exp_g;
        w = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
        dn_wr_en = 1'b1; dn_wr_data = w;
        tick();
        dn_wr_en = 1'b0;
        n_checks++; if (dn_rd_level !== 7'd8) begin n_fail++; $display("FAIL dn_rd_level got %0d exp 8", dn_rd_level); end
        n_checks++; if (dn_wr_level !== 7'd1) begin n_fail++; $display("FAIL dn_wr_level got %0d exp 1", dn_wr_level); end
        n_checks++; if (dn_rd_empty !== 1'b0) begin n_fail++; $display("FAIL dn_rd_empty_pre got %b exp 0", dn_rd_empty); end
        for (int k = 0; k < 8; k++) begin
            dn_rd_en = 1'b1;
            tick();
            exp_g = w[127 - 16*k -: 16];
            $display("dn read %0d data %h", k, dn_rd_data);
            n_checks++; if (dn_rd_data !== exp_g)
                begin n_fail++; $display("FAIL dn_data_%0d got %h exp %h", k, dn_rd_data, exp_g); end
            n_checks++; if (dn_rd_empty !== (k == 7))
                begin n_fail++; $display("FAIL dn_empty_%0d got %b exp %b", k, dn_rd_empty, (k == 7)); end
            n_checks++; if (dn_almost_empty !== ((7 - k) <= 2))
                begin n_fail++; $display("FAIL dn_ae_%0d got %b exp %b", k, dn_almost_empty, ((7 - k) <= 2)); end
        end
        dn_rd_en = 1'b0;
    endtask

    task automatic test_down_full();
        for (int k = 0; k < 8; k++) begin
            dn_wr_en = 1'b1; dn_wr_data = {8{16'h1000 + 16'(k)}};
            tick();
            n_checks++; if (dn_almost_full !== (k >= 6))
                begin n_fail++; $display("FAIL dnfull_af_%0d got %b exp %b", k, dn_almost_full, (k >= 6)); end
            n_checks++; if (dn_wr_full !== (k == 7))
                begin n_fail++; $display("FAIL dnfull_full_%0d got %b exp %b", k, dn_wr_full, (k == 7)); end
        end
        dn_wr_en = 1'b0; dn_rd_en = 1'b1;
        tick();
        dn_rd_en = 1'b0;
        $display("dn read while full, data %h", dn_rd_data);
        n_checks++; if (dn_rd_data !== 16'h1000) begin n_fail++; $display("FAIL dnfull_data got %h exp 1000", dn_rd_data); end
        n_checks++; if (dn_wr_full !== 1'b1)     begin n_fail++; $display("FAIL dnfull_one_free got %b exp 1", dn_wr_full); end
        n_checks++; if (dn_wr_level !== 7'd7)    begin n_fail++; $display("FAIL dnfull_wr_level got %0d exp 7", dn_wr_level); end
        n_checks++; if (dn_rd_level !== 7'd63)   begin n_fail++; $display("FAIL dnfull_rd_level got %0d exp 63", dn_rd_level); end
        dn_wr_en = 1'b1; dn_wr_data = '1;
        tick();
        dn_wr_en = 1'b0;
        n_checks++; if (dn_rd_level !== 7'd63)   begin n_fail++; $display("FAIL dnfull_write_blocked got %0d exp 63", dn_rd_level); end
        dn_clr = 1'b1;
        tick();
        dn_clr = 1'b0;
        n_checks++; if (dn_rd_empty !== 1'b1 || dn_wr_full !== 1'b0 || dn_rd_data !== 16'h1000)
            begin n_fail++; $display("FAIL dnfull_clr got empty=%b full=%b data=%h exp 1/0/1000", dn_rd_empty, dn_wr_full, dn_rd_data); end
    endtask

    initial begin
        rst = 1'b1;
        up_clr = 1'b0; up_wr_en = 1'b0; up_rd_en = 1'b0; up_wr_data = '0;
        dn_clr = 1'b0; dn_wr_en = 1'b0; dn_rd_en = 1'b0; dn_wr_data = '0;
        test_reset();
        test_pack();
        test_partial();
        test_clear();
        test_fill_and_wrap();
        test_down();
        test_down_full();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
